imem_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the pipeline's instruction memory write port. It accepts a byte stream over a valid/ready handshake, frames it as length header + big-endian instruction words + XOR checksum, writes each word into instruction memory, and holds the pipeline core in reset until a checksum-verified image is resident. It drives the instruction memory's write-enable/address/data inputs and the core reset.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/word_packer.sv | 47 ++++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state
// encoding and the framing constants of the byte stream.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   // Stream framing: 2-byte length header, 4 bytes per word, 1 checksum byte.
   localparam int unsigned LEN_BYTES      = 2;
   localparam int unsigned CSUM_BYTES     = 1;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs an MSB-first byte stream into 32-bit words. word_o is valid in the
// cycle word_done_o is high, which is the cycle the 4th byte is accepted.
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   // Next-state: shift in a byte when enabled; clear restarts word alignment.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         shift_d = {shift_q[15:0], byte_i};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   // The current byte completes the word, so it is concatenated directly.
   always_comb begin
      word_o      = {shift_q, byte_i};
      word_done_o = en_i && !clr_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
   end

   // Shift register and byte counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: receives length + big-endian words + XOR
// checksum over a byte handshake, writes each word into instruction memory
// and releases the core reset only once the checksum has been verified.
//
// Handshake: a byte transfers on a rising clk edge where byte_vld_i and
// byte_rdy_o are both 1. byte_rdy_o is decoded from the state register only
// (1 in LEN/DATA/CSUM), never from byte_vld_i; the sender must hold byte_i
// stable while byte_vld_i=1 and the byte has not yet been accepted.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_i,
   output logic        byte_rdy_o,
   output logic        wr_en_imem_o,
   output logic [31:0] wr_addr_imem_o,
   output logic [31:0] wr_instr_imem_o,
   output logic        core_reset_o,
   output logic        done_o,
   output logic        err_o
);

   state_e      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  csum_q, csum_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_instr_q, wr_instr_d;
   logic        core_reset_q, core_reset_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        accept;
   logic [15:0] hdr_len;
   logic        pk_clr, pk_en, pk_done;
   logic [31:0] pk_word;

   word_packer u_word_packer (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (pk_clr),
      .en_i        (pk_en),
      .byte_i      (byte_i),
      .word_o      (pk_word),
      .word_done_o (pk_done)
   );

   // Ready decode and header assembly (header bytes shift in MSB first).
   always_comb begin
      byte_rdy_o = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
      accept     = byte_vld_i && byte_rdy_o;
      hdr_len    = {len_q[7:0], byte_i};
   end

   // FSM next-state plus counter, checksum and output register updates.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      len_d        = len_q;
      idx_d        = idx_q;
      csum_d       = csum_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_instr_d   = wr_instr_q;
      core_reset_d = core_reset_q;
      done_d       = done_q;
      err_d        = err_q;
      pk_clr       = 1'b0;
      pk_en        = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d      = ST_LEN;
               byte_cnt_d   = '0;
               len_d        = '0;
               idx_d        = '0;
               csum_d       = '0;
               core_reset_d = 1'b1;
               done_d       = 1'b0;
               err_d        = 1'b0;
               pk_clr       = 1'b1;
            end
         end
         ST_LEN: begin
            if (accept) begin
               len_d = hdr_len;
               if (byte_cnt_q == 2'(LEN_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  if ((hdr_len == 16'd0) || (32'(hdr_len) > MAX_WORDS)) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ byte_i;
               pk_en  = 1'b1;
               if (pk_done) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = BASE_ADDR + 32'({idx_q, 2'b00});
                  wr_instr_d = pk_word;
                  idx_d      = idx_q + 16'd1;
                  if ((idx_q + 16'd1) == len_q) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (byte_cnt_q == 2'(CSUM_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  if (byte_i == csum_q) begin
                     state_d      = ST_DONE;
                     done_d       = 1'b1;
                     core_reset_d = 1'b0;
                  end else begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset holds the core and clears the port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         csum_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_instr_q   <= '0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         csum_q       <= csum_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_instr_q   <= wr_instr_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Registered outputs.
   always_comb begin
      wr_en_imem_o    = wr_en_q;
      wr_addr_imem_o  = wr_addr_q;
      wr_instr_imem_o = wr_instr_q;
      core_reset_o    = core_reset_q;
      done_o          = done_q;
      err_o           = err_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share the stream: one at
// base address 0, one at 0x0040_0000. Every issued word pushes its expected
// write into a per-instance queue; a negedge monitor pops on each write pulse.
module tb_imem_loader;

   localparam logic [31:0] BASE1 = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_vld;
   logic [7:0]  byte_in;

   logic        rdy0, wr_en0, core_reset0, done0, err0;
   logic [31:0] wr_addr0, wr_instr0;
   logic        rdy1, wr_en1, core_reset1, done1, err1;
   logic [31:0] wr_addr1, wr_instr1;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp0_q[$];
   logic [63:0] exp1_q[$];
   logic [31:0] img_q[$];

   // Clock and DUTs.
   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
      .clk(clk), .reset(rst), .start_i(start), .byte_vld_i(byte_vld), .byte_i(byte_in),
      .byte_rdy_o(rdy0), .wr_en_imem_o(wr_en0), .wr_addr_imem_o(wr_addr0),
      .wr_instr_imem_o(wr_instr0), .core_reset_o(core_reset0), .done_o(done0), .err_o(err0)
   );

   imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(256)) dut1 (
      .clk(clk), .reset(rst), .start_i(start), .byte_vld_i(byte_vld), .byte_i(byte_in),
      .byte_rdy_o(rdy1), .wr_en_imem_o(wr_en1), .wr_addr_imem_o(wr_addr1),
      .wr_instr_imem_o(wr_instr1), .core_reset_o(core_reset1), .done_o(done1), .err_o(err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      logic [63:0] e;
      if (wr_en0) begin
         if (exp0_q.size() == 0) begin
            check("dut0_spurious_write", {31'd0, wr_en0}, 32'd0);
         end else begin
            e = exp0_q.pop_front();
            check("dut0_wr_addr", wr_addr0, e[63:32]);
            check("dut0_wr_data", wr_instr0, e[31:0]);
         end
      end
      if (wr_en1) begin
         if (exp1_q.size() == 0) begin
            check("dut1_spurious_write", {31'd0, wr_en1}, 32'd0);
         end else begin
            e = exp1_q.pop_front();
            check("dut1_wr_addr", wr_addr1, e[63:32]);
            check("dut1_wr_data", wr_instr1, e[31:0]);
         end
      end
   end

   // Present one byte and wait (bounded) for it to be accepted; gap adds an idle cycle.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited = 0;
      @(negedge clk);
      byte_vld = 1'b1;
      byte_in  = b;
      while (!rdy0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!rdy0) begin
         check("byte_rdy_timeout", {31'd0, rdy0}, 32'd1);
      end else begin
         @(posedge clk);
      end
      #1;
      byte_vld = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Send header, the words in img_q (pushing expected writes), then checksum.
   task automatic load_image(input logic [15:0] n, input logic [7:0] csum, input bit gap);
      logic [31:0] w;
      send_byte(n[15:8], gap);
      send_byte(n[7:0], gap);
      for (int i = 0; i < img_q.size(); i++) begin
         w = img_q[i];
         exp0_q.push_back({32'(4 * i), w});
         exp1_q.push_back({BASE1 + 32'(4 * i), w});
         for (int j = 0; j < 4; j++) begin
            send_byte(w[31 - 8 * j -: 8], gap);
         end
      end
      send_byte(csum, gap);
   endtask

   task automatic check_result(input string tag, input bit exp_done, input bit exp_err);
      @(negedge clk);
      check({tag, "_done0"}, {31'd0, done0}, {31'd0, exp_done});
      check({tag, "_err0"}, {31'd0, err0}, {31'd0, exp_err});
      check({tag, "_core_reset0"}, {31'd0, core_reset0}, {31'd0, !exp_done});
      check({tag, "_done1"}, {31'd0, done1}, {31'd0, exp_done});
      check({tag, "_err1"}, {31'd0, err1}, {31'd0, exp_err});
      check({tag, "_rdy0"}, {31'd0, rdy0}, 32'd0);
      check({tag, "_q0_left"}, 32'(exp0_q.size()), 32'd0);
      check({tag, "_q1_left"}, 32'(exp1_q.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rdy"}, {31'd0, rdy0}, 32'd0);
      check({tag, "_wr_en"}, {31'd0, wr_en0}, 32'd0);
      check({tag, "_wr_addr"}, wr_addr0, 32'd0);
      check({tag, "_wr_instr"}, wr_instr0, 32'd0);
      check({tag, "_core_reset"}, {31'd0, core_reset0}, 32'd1);
      check({tag, "_done"}, {31'd0, done0}, 32'd0);
      check({tag, "_err"}, {31'd0, err0}, 32'd0);
      check({tag, "_wr_addr1"}, wr_addr1, 32'd0);
   endtask

   task automatic load_small_image();
      img_q = '{32'h2008_0005, 32'h0000_0000};
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      byte_vld = 1'b0;
      byte_in  = 8'h00;
      @(negedge clk);
      check_reset_values("por");
      @(negedge clk);
      rst = 1'b0;

      // Two words at full rate; checksum 20^08^00^05^00^00^00^00 = 2D.
      load_small_image();
      pulse_start();
      load_image(16'd2, 8'h2D, 1'b0);
      check_result("full_rate", 1'b1, 1'b0);

      // Restart from DONE: core reset must come back the cycle after start.
      pulse_start();
      check("restart_core_reset", {31'd0, core_reset0}, 32'd1);
      check("restart_done_clr", {31'd0, done0}, 32'd0);
      load_image(16'd2, 8'h2D, 1'b1);
      check_result("gapped", 1'b1, 1'b0);

      // Zero-length header: error right after the second header byte, no writes.
      img_q = {};
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check_result("len_zero", 1'b0, 1'b1);

      // Length 257 exceeds the 256-word limit.
      pulse_start();
      check("err_clr_on_start", {31'd0, err0}, 32'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check_result("len_over", 1'b0, 1'b1);

      // Correct payload, wrong checksum: writes happen, then error.
      load_small_image();
      pulse_start();
      load_image(16'd2, 8'h2C, 1'b0);
      check_result("bad_csum", 1'b0, 1'b1);

      // Three words; checksum 08 ^ 22 ^ FF = D5.
      img_q = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00FF};
      pulse_start();
      load_image(16'd3, 8'hD5, 1'b0);
      check_result("three_words", 1'b1, 1'b0);

      // New image from DONE: A5^A5^0F^0F = 00.
      img_q = '{32'hA5A5_0F0F};
      pulse_start();
      check("reload_core_reset", {31'd0, core_reset1}, 32'd1);
      load_image(16'd1, 8'h00, 1'b0);
      check_result("reload", 1'b1, 1'b0);

      // Exactly the word limit; each word repeats one byte so the checksum is 00.
      img_q = {};
      for (int i = 0; i < 256; i++) begin
         img_q.push_back({4{8'(i)}});
      end
      pulse_start();
      load_image(16'd256, 8'h00, 1'b0);
      check_result("max_words", 1'b1, 1'b0);

      // Reset in the middle of the payload, away from any clock edge.
      img_q = {};
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      load_small_image();
      pulse_start();
      load_image(16'd2, 8'h2D, 1'b0);
      check_result("after_reset", 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
